// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/multu/div/divu over a
// fixed number of cycles and serves mfhi/mflo combinationally.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDUStart_E,
    input  logic [3:0]  MDUOp_E,
    input  logic [31:0] SrcA_E,
    input  logic [31:0] SrcB_E,
    output logic        Busy,
    output logic [31:0] MDUOut_E,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_sh;
    logic [31:0]   r_sl;
    logic          r_nowr;

    logic          w_busy;
    logic          w_accept;
    logic          w_is_div;
    logic          w_div0;
    logic [63:0]   w_res;
    logic [CW-1:0] w_load;

    // Result of a start op as {HI, LO}; divide-by-zero yields 0 and is flagged separately.
    function automatic logic [63:0] f_mdu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        logic [63:0] res;
        ea  = 64'd0;
        eb  = 64'd0;
        ma  = (a[31] == 1'b1) ? (~a + 32'd1) : a;
        mb  = (b[31] == 1'b1) ? (~b + 32'd1) : b;
        q   = 32'd0;
        r   = 32'd0;
        res = 64'd0;
        case (op)
            OP_MULT: begin
                ea  = {{32{a[31]}}, a};
                eb  = {{32{b[31]}}, b};
                res = ea * eb;
            end
            OP_MULTU: begin
                ea  = {32'd0, a};
                eb  = {32'd0, b};
                res = ea * eb;
            end
            OP_DIV: begin
                if (b != 32'd0) begin
                    q   = ma / mb;
                    r   = ma % mb;
                    q   = ((a[31] ^ b[31]) == 1'b1) ? (~q + 32'd1) : q;
                    r   = (a[31] == 1'b1) ? (~r + 32'd1) : r;
                    res = {r, q};
                end else begin
                    res = 64'd0;
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    res = {a % b, a / b};
                end else begin
                    res = 64'd0;
                end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    assign w_busy   = (r_cnt != '0);
    assign w_accept = MDUStart_E && !w_busy && (MDUOp_E >= OP_MULT) && (MDUOp_E <= OP_DIVU);
    assign w_is_div = (MDUOp_E == OP_DIV) || (MDUOp_E == OP_DIVU);

    // Operand-side decode: shadow result, divide-by-zero flag and cycle budget.
    always_comb begin
        w_res  = f_mdu(MDUOp_E, SrcA_E, SrcB_E);
        w_div0 = 1'b0;
        w_load = CW'(MULT_CYCLES);
        if (w_is_div) begin
            w_div0 = (SrcB_E == 32'd0);
            w_load = CW'(DIV_CYCLES);
        end else begin
            w_div0 = 1'b0;
            w_load = CW'(MULT_CYCLES);
        end
    end

    // Counter, shadow result and HI/LO; mthi/mtlo only land while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_sh   <= 32'd0;
            r_sl   <= 32'd0;
            r_nowr <= 1'b0;
        end else if (w_accept) begin
            r_sh   <= w_res[63:32];
            r_sl   <= w_res[31:0];
            r_nowr <= w_div0;
            r_cnt  <= w_load;
        end else if (r_cnt == CW'(1)) begin
            r_cnt <= '0;
            if (!r_nowr) begin
                r_hi <= r_sh;
                r_lo <= r_sl;
            end
        end else if (w_busy) begin
            r_cnt <= r_cnt - CW'(1);
        end else if (MDUOp_E == OP_MTHI) begin
            r_hi <= SrcA_E;
        end else if (MDUOp_E == OP_MTLO) begin
            r_lo <= SrcA_E;
        end
    end

    // mfhi/mflo read path; while busy it deliberately returns the old value.
    always_comb begin
        MDUOut_E = 32'd0;
        case (MDUOp_E)
            OP_MFHI: MDUOut_E = r_hi;
            OP_MFLO: MDUOut_E = r_lo;
            default: MDUOut_E = 32'd0;
        endcase
    end

    assign Busy = w_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Directed, table-driven bench for e_mdu with hand-written multi-cycle sequences.
module tb_e_mdu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic [31:0] mdu_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_errors;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .MDUStart_E (start),
        .MDUOp_E    (op),
        .SrcA_E     (srca),
        .SrcB_E     (srcb),
        .Busy       (busy),
        .MDUOut_E   (mdu_out),
        .HI         (hi),
        .LO         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start op, then count the cycles Busy stays high (bounded).
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int nb, output logic held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        op = o; srca = a; srcb = b; start = 1'b1;
        step();
        start = 1'b0; op = 4'd0;
        nb = 0;
        held = 1'b1;
        while (busy && nb < 200) begin
            nb++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            step();
        end
    endtask

    initial begin
        int   nb;
        logic held;

        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{"mult_neg1x2",   4'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1] = '{"multu_ffx2",    4'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{"div_m7_2",      4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{"divu_7_2",      4'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[4] = '{"div_min_m1",    4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{"div_7_m2",      4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[6] = '{"mult_2p16sq",   4'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[7] = '{"multu_maxsq",   4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[8] = '{"mult_m1xm1",    4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
        vecs[9] = '{"divu_max_10",   4'd4, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 10};

        rst_n = 1'b0; start = 1'b0; op = 4'd0; srca = 32'd0; srcb = 32'd0;
        #23 rst_n = 1'b1;
        step();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, nb, held);
            check({vecs[i].name, "_cycles"}, nb, vecs[i].n);
            check({vecs[i].name, "_hold"}, {31'd0, held}, 32'd1);
            check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
        end

        // mthi then mtlo, read back through mfhi/mflo
        op = 4'd7; srca = 32'h12345678; step();
        op = 4'd8; srca = 32'h9ABCDEF0; step();
        op = 4'd5; #1 check("mfhi", mdu_out, 32'h12345678);
        op = 4'd6; #1 check("mflo", mdu_out, 32'h9ABCDEF0);
        op = 4'd0; #1 check("out_none", mdu_out, 32'd0);
        op = 4'd9; #1 check("out_bad_op", mdu_out, 32'd0);

        // op 1..4 without Start does nothing
        op = 4'd1; srca = 32'd3; srcb = 32'd4; start = 1'b0; step();
        check("nostart_busy", {31'd0, busy}, 32'd0);
        check("nostart_lo", lo, 32'h9ABCDEF0);

        // mthi and a second Start while busy are both ignored
        nb = 0;
        op = 4'd1; srca = 32'd3; srcb = 32'd4; start = 1'b1; step();
        if (busy) nb++;
        op = 4'd7; srca = 32'hDEADBEEF; start = 1'b0; step();
        if (busy) nb++;
        check("mthi_busy_drop", hi, 32'h12345678);
        op = 4'd5; #1 check("mfhi_busy_old", mdu_out, 32'h12345678);
        op = 4'd1; srca = 32'd100; srcb = 32'd100; start = 1'b1; step();
        if (busy) nb++;
        start = 1'b0; op = 4'd0;
        for (int k = 0; k < 50 && busy; k++) begin
            step();
            if (busy) nb++;
        end
        check("restart_cycles", nb, 5);
        check("restart_hi", hi, 32'd0);
        check("restart_lo", lo, 32'd12);

        // divide by zero keeps HI/LO
        op = 4'd7; srca = 32'd5; step();
        op = 4'd8; srca = 32'd6; step();
        issue(4'd3, 32'd9, 32'd0, nb, held);
        check("div0_cycles", nb, 10);
        check("div0_hi", hi, 32'd5);
        check("div0_lo", lo, 32'd6);
        issue(4'd4, 32'd9, 32'd0, nb, held);
        check("divu0_lo", lo, 32'd6);

        // async reset during the 3rd busy cycle of a mult
        op = 4'd1; srca = 32'd7; srcb = 32'd7; start = 1'b1; step();
        start = 1'b0; op = 4'd0;
        step();
        step();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        held = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (busy || hi !== 32'd0 || lo !== 32'd0) held = 1'b0;
        end
        check("postrst_nowrite", {31'd0, held}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the E stage. It sits directly downstream of the decode stage and consumes the MDUOp/MDUStart control and the forwarded rs/rt operands that decode produces.
- Owns the architectural HI/LO registers and executes mult/multu/div/divu over multiple cycles with a Busy flag.
- Serves mfhi/mflo reads combinationally; MDUOut is registered into M by the E/M pipeline register.
- The hazard unit uses Start and Busy to stall decode.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy is high for mult/multu (must be ≥1).
- DIV_CYCLES, 10, number of cycles Busy is high for div/divu (must be ≥1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MDUStart_E  in  1  an MDU start op (mult/multu/div/divu) is valid in E this cycle.
- MDUOp_E  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; other codes behave as none.
- SrcA_E  in  32  forwarded rs value.
- SrcB_E  in  32  forwarded rt value.
- Busy  out  1  a multi-cycle operation is in progress.
- MDUOut_E  out  32  HI when op=5, LO when op=6, else 0.
- HI  out  32  current HI register.
- LO  out  32  current LO register.

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, cnt=0, Busy=0, shadow result regs=0. Effect is immediate, including mid-operation: any pending result is discarded and HI/LO are not updated.
- State: idle when cnt==0, running when cnt!=0. Busy = (cnt!=0), decoded from the registered counter only.
- Accept: at a rising edge with MDUStart_E=1, Busy=0 and op in 1..4:
  - compute the 64-bit result from SrcA_E/SrcB_E into shadow regs sH/sL;
  - load cnt=MULT_CYCLES for ops 1/2, or DIV_CYCLES for ops 3/4.
- Start while Busy=1: ignored entirely (no reload, no operand capture). The hazard unit guarantees this does not occur.
- Running: each edge with cnt>1 decrements cnt. At the edge with cnt==1: HI<=sH, LO<=sL, cnt<=0.
  - For Start sampled at the edge ending cycle T, Busy is high in cycles T+1..T+N.
  - New HI/LO are visible from cycle T+N+1, where Busy is 0.
- Result arithmetic:
  - mult: signed 32x32→64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32→64.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient in LO, unsigned remainder in HI.
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
  - div/divu by zero: counter still runs the full DIV_CYCLES; at completion HI/LO keep their prior values (no write).
- mthi/mtlo (ops 7/8): at the edge, if Busy=0, write SrcA_E into HI or LO. If Busy=1 the write is dropped.
- Same-edge conflicts:
  - A completion write has priority over nothing else; no same-edge conflict can arise, because mthi/mtlo require Busy=0 and completion occurs only with Busy=1.
- MDUOut_E is purely combinational from op and current HI/LO. mfhi while Busy=1 returns the old HI (the hazard unit must stall it).
- MDUStart_E=0 with op 1..4: treated as no operation.

Test Plan:
- Reset, then mult SrcA=0xFFFFFFFF, SrcB=2, Start=1 for one cycle → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. HI/LO unchanged (0) while Busy.
- multu with the same operands → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div SrcA=0xFFFFFFF9 (-7), SrcB=2 → Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 → LO=3, HI=1.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on the next cycle, then mfhi/mflo → MDUOut_E=0x12345678 / 0x9ABCDEF0.
- mthi issued while Busy → HI unchanged. Start issued while Busy → Busy duration not extended and the result is from the first operands.
- div by 0 after HI=5, LO=6 → Busy 10 cycles, then HI=5, LO=6. Assert reset in the 3rd Busy cycle of a mult → Busy=0, HI=LO=0 immediately; no later write occurs.
